ring_arbiter16: RTL



---
 rtl/ring_arbiter16_pkg.sv | 14 +
 rtl/onehot_enc16.sv | 16 +
 rtl/ring_arbiter16.sv | 102 ++++++++++
 3 files changed

// File: rtl/ring_arbiter16_pkg.sv
// Shared constants and state encoding for the 16-way rotating-token arbiter.
package ring_arbiter16_pkg;

  localparam int N    = 16;
  localparam int IDXW = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [N-1:0] PTR_RST = 16'h0001;

endpackage

// File: rtl/onehot_enc16.sv
// 16-to-4 one-hot to binary OR encoder; an all-zero input encodes to 0.
module onehot_enc16
  import ring_arbiter16_pkg::*;
(
  input  logic [N-1:0]    oh,
  output logic [IDXW-1:0] idx
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) idx = idx | IDXW'(i);
    end
  end

endmodule

// File: rtl/ring_arbiter16.sv
// Round-robin arbiter for 16 requesters: rotating one-hot priority token,
// grant held until DONE, request drop or MAX_HOLD expiry.
module ring_arbiter16
  import ring_arbiter16_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N-1:0]    REQ,
  input  logic            DONE,
  output logic [N-1:0]    GNT,
  output logic [IDXW-1:0] GNT_IDX,
  output logic            GNT_VLD,
  output logic            TIMEOUT,
  output logic [N-1:0]    PTR
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;

  state_t          state;
  logic [N-1:0]    gnt_p1;
  logic [N-1:0]    ptr_p1;
  logic            vld_p1;
  logic            tmo_p1;
  logic [HW-1:0]   hold_p1;

  logic [IDXW-1:0] gnt_idx;
  logic [IDXW-1:0] ptr_idx;
  logic [IDXW-1:0] nxt_idx;
  logic [IDXW-1:0] sel_idx;
  logic [IDXW-1:0] cand;
  logic            sel_found;
  logic            req_held;
  logic            hold_hit;

  onehot_enc16 u_enc_gnt (.oh(gnt_p1), .idx(gnt_idx));
  onehot_enc16 u_enc_ptr (.oh(ptr_p1), .idx(ptr_idx));

  // Circular search starting at the token position; 4-bit add wraps 15 -> 0.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = ptr_idx + IDXW'(k);
      if (!sel_found && REQ[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign nxt_idx  = gnt_idx + 1'b1;
  assign req_held = |(REQ & gnt_p1);
  assign hold_hit = (MAX_HOLD != 0) && (hold_p1 == HOLD_LAST);

  // Stage p1: registered grant, token, timeout pulse and hold counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      gnt_p1  <= '0;
      vld_p1  <= 1'b0;
      tmo_p1  <= 1'b0;
      ptr_p1  <= PTR_RST;
      hold_p1 <= '0;
    end else begin
      tmo_p1 <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_found) begin
            gnt_p1  <= PTR_RST << sel_idx;
            vld_p1  <= 1'b1;
            hold_p1 <= '0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (DONE || !req_held || hold_hit) begin
            gnt_p1 <= '0;
            vld_p1 <= 1'b0;
            ptr_p1 <= PTR_RST << nxt_idx;
            // Only a pure expiry pulses TIMEOUT; DONE or a drop wins the tie.
            tmo_p1 <= hold_hit && !DONE && req_held;
            state  <= IDLE;
          end else if (hold_p1 != '1) begin
            hold_p1 <= hold_p1 + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign GNT     = gnt_p1;
  assign GNT_IDX = gnt_idx;
  assign GNT_VLD = vld_p1;
  assign TIMEOUT = tmo_p1;
  assign PTR     = ptr_p1;

endmodule
